lfsr_prng_checker: RTL and testbench

Receive-side checker for the 32-bit XNOR LFSR random-number stream that drives MBPTA randomised cache placement and replacement. It samples the generator's output bit 0 serially, which is the bit shifted into the LFSR each cycle. It self-synchronises to the generator state, then predicts every subsequent bit and flags mismatches and lock-up. It sits beside the IFU PRNG as a health monitor; its status feeds debug CSRs and an error interrupt.

---
 rtl/veer_types.sv | 20 ++
 rtl/lfsr_prng_checker_if.sv | 25 ++
 rtl/lfsr_prng.sv | 28 ++
 rtl/lfsr_prng_checker.sv | 111 +++++++++++
 tb/tb_lfsr_prng_checker.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/veer_types.sv
// Shared LFSR definitions for the PRNG generator and its receive-side checker.
package veer_types;

   localparam int unsigned LFSR_W = 32;
   localparam int unsigned TAP_A  = 31;
   localparam int unsigned TAP_B  = 23;
   localparam int unsigned TAP_C  = 15;
   localparam int unsigned TAP_D  = 7;

   typedef enum logic {
      CHK_FILL  = 1'b0,
      CHK_CHECK = 1'b1
   } chk_state_e;

   // XNOR feedback; the all-ones state maps onto itself (lock-up).
   function automatic logic lfsr_newbit(input logic [LFSR_W-1:0] s);
      return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
   endfunction

endpackage

// File: rtl/lfsr_prng_checker_if.sv
// Sample stream and status bundle between the PRNG tap and its health checker.
interface lfsr_prng_checker_if #(
   parameter int unsigned CNT_W = 16
);

   logic             valid_i;
   logic             bit_i;
   logic             clear_i;
   logic             locked_o;
   logic             err_pulse_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic             stuck_o;
   logic             fail_o;

   modport master (
      output valid_i, bit_i, clear_i,
      input  locked_o, err_pulse_o, err_cnt_o, stuck_o, fail_o
   );

   modport slave (
      input  valid_i, bit_i, clear_i,
      output locked_o, err_pulse_o, err_cnt_o, stuck_o, fail_o
   );

endinterface

// File: rtl/lfsr_prng.sv
// XNOR LFSR random source; SIZE independent 32-bit lanes, advanced together on i_en.
module lfsr_prng
   import veer_types::*;
#(
   parameter int unsigned SIZE = 1
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic                     i_en,
   output logic [SIZE*LFSR_W-1:0]   o_rnd
);

   for (genvar g = 0; g < SIZE; g++) begin : g_lane
      logic [LFSR_W-1:0] r_s;

      // Shift the feedback bit into bit 0 on every enable; lane g seeds with value g.
      always_ff @(posedge clk or negedge rst_l) begin
         if (!rst_l) begin
            r_s <= LFSR_W'(g);
         end else if (i_en) begin
            r_s <= {r_s[LFSR_W-2:0], lfsr_newbit(r_s)};
         end
      end

      assign o_rnd[g*LFSR_W +: LFSR_W] = r_s;
   end

endmodule

// File: rtl/lfsr_prng_checker.sv
// Serial checker for the XNOR LFSR stream: fills a shadow register from the observed
// bits, then predicts each next bit, counting mismatches and dropping lock on a run.
module lfsr_prng_checker
   import veer_types::*;
#(
   parameter int unsigned ERR_THRESH = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_l,
   lfsr_prng_checker_if.slave   chk
);

   localparam int unsigned FILL_W = $clog2(LFSR_W);
   localparam int unsigned CONS_W = $clog2(ERR_THRESH + 1);

   logic [LFSR_W-1:0] r_s,       w_s_d;
   chk_state_e        r_state,   w_state_d;
   logic [FILL_W-1:0] r_fill,    w_fill_d;
   logic [CONS_W-1:0] r_consec,  w_consec_d;
   logic [CNT_W-1:0]  r_err_cnt, w_err_cnt_d;
   logic              r_pulse,   w_pulse_d;
   logic              r_fail,    w_fail_d;

   logic              w_pred;
   logic              w_mismatch;
   logic [CONS_W-1:0] w_consec_inc;

   assign w_pred       = lfsr_newbit(r_s);
   assign w_mismatch   = chk.valid_i && (r_state == CHK_CHECK) && (chk.bit_i != w_pred);
   assign w_consec_inc = r_consec + 1'b1;

   // Next-state: clear lands first so a same-cycle mismatch still counts and can set fail.
   always_comb begin
      w_s_d       = r_s;
      w_state_d   = r_state;
      w_fill_d    = r_fill;
      w_consec_d  = r_consec;
      w_err_cnt_d = r_err_cnt;
      w_pulse_d   = 1'b0;
      w_fail_d    = r_fail;

      if (chk.clear_i) begin
         w_err_cnt_d = '0;
         w_fail_d    = 1'b0;
      end

      if (chk.valid_i) begin
         // Observed bit always enters history, even when it mismatches.
         w_s_d = {r_s[LFSR_W-2:0], chk.bit_i};
         unique case (r_state)
            CHK_FILL: begin
               if (r_fill == FILL_W'(LFSR_W - 1)) begin
                  w_state_d  = CHK_CHECK;
                  w_fill_d   = '0;
                  w_consec_d = '0;
               end else begin
                  w_fill_d = r_fill + 1'b1;
               end
            end
            CHK_CHECK: begin
               if (w_mismatch) begin
                  w_pulse_d = 1'b1;
                  if (w_err_cnt_d != '1) begin
                     w_err_cnt_d = w_err_cnt_d + 1'b1;
                  end
                  if (w_consec_inc == CONS_W'(ERR_THRESH)) begin
                     w_state_d  = CHK_FILL;
                     w_fill_d   = '0;
                     w_consec_d = '0;
                     w_fail_d   = 1'b1;
                  end else begin
                     w_consec_d = w_consec_inc;
                  end
               end else begin
                  w_consec_d = '0;
               end
            end
         endcase
      end
   end

   // State registers with asynchronous active-low reset back into FILL.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_s       <= '0;
         r_state   <= CHK_FILL;
         r_fill    <= '0;
         r_consec  <= '0;
         r_err_cnt <= '0;
         r_pulse   <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_s       <= w_s_d;
         r_state   <= w_state_d;
         r_fill    <= w_fill_d;
         r_consec  <= w_consec_d;
         r_err_cnt <= w_err_cnt_d;
         r_pulse   <= w_pulse_d;
         r_fail    <= w_fail_d;
      end
   end

   assign chk.locked_o    = (r_state == CHK_CHECK);
   assign chk.err_pulse_o = r_pulse;
   assign chk.err_cnt_o   = r_err_cnt;
   assign chk.fail_o      = r_fail;
   // A stuck XNOR generator keeps matching, so lock-up is only reported, never acted on.
   assign chk.stuck_o     = (r_state == CHK_CHECK) && (&r_s);

endmodule

// File: tb/tb_lfsr_prng_checker.sv
// Scoreboard bench: history-based reference model, decoupled output monitor.
module tb_lfsr_prng_checker;
   import veer_types::*;

   localparam int unsigned THRESH = 4;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        gen_en;
   logic [31:0] gen_rnd;

   always #5 clk = ~clk;

   lfsr_prng_checker_if #(.CNT_W(16)) bus16 ();
   lfsr_prng_checker_if #(.CNT_W(2))  bus2 ();

   lfsr_prng #(.SIZE(1)) u_gen (
      .clk   (clk),
      .rst_l (rst_l),
      .i_en  (gen_en),
      .o_rnd (gen_rnd)
   );

   lfsr_prng_checker #(.ERR_THRESH(THRESH), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_l (rst_l),
      .chk   (bus16)
   );

   lfsr_prng_checker #(.ERR_THRESH(THRESH), .CNT_W(2)) u_dut2 (
      .clk   (clk),
      .rst_l (rst_l),
      .chk   (bus2)
   );

   typedef struct {
      bit          locked;
      bit          pulse;
      bit          stuck;
      bit          fail;
      int unsigned cnt16;
      int unsigned cnt2;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_err = 0;

   // Reference model state: every observed sample since reset, plus status.
   bit          hist[$];
   bit          ghist[$];
   int          fill_start;
   bit          m_locked;
   int          consec;
   int unsigned cnt16;
   int unsigned cnt2;
   bit          m_fail;

   function automatic bit hbit(input int i);
      if (i < 0) return 1'b0;
      return hist[i];
   endfunction

   function automatic bit gbit(input int i);
      if (i < 0) return 1'b0;
      return ghist[i];
   endfunction

   task automatic model_reset();
      hist.delete();
      ghist.delete();
      fill_start = 0;
      m_locked   = 1'b0;
      consec     = 0;
      cnt16      = 0;
      cnt2       = 0;
      m_fail     = 1'b0;
   endtask

   // One clock edge of the model; pushes the outputs expected after that edge.
   task automatic model_edge(input bit v, input bit b, input bit clr);
      exp_t e;
      bit   pulse;
      bit   pred;
      bit   ones;
      int   n;
      pulse = 1'b0;
      if (clr) begin
         cnt16  = 0;
         cnt2   = 0;
         m_fail = 1'b0;
      end
      if (v) begin
         n = hist.size();
         if (!m_locked) begin
            if (n + 1 - fill_start == 32) begin
               m_locked = 1'b1;
               consec   = 0;
            end
         end else begin
            // Sample n is predicted from the samples 32, 24, 16 and 8 back.
            pred = ~(hbit(n - 32) ^ hbit(n - 24) ^ hbit(n - 16) ^ hbit(n - 8));
            if (b != pred) begin
               pulse = 1'b1;
               if (cnt16 < 65535) cnt16++;
               if (cnt2 < 3) cnt2++;
               consec++;
               if (consec == THRESH) begin
                  m_locked   = 1'b0;
                  m_fail     = 1'b1;
                  consec     = 0;
                  fill_start = n + 1;
               end
            end else begin
               consec = 0;
            end
         end
         hist.push_back(b);
      end
      n    = hist.size();
      ones = 1'b1;
      for (int i = 1; i <= 32; i++) if (hbit(n - i) == 1'b0) ones = 1'b0;
      e.locked = m_locked;
      e.pulse  = pulse;
      e.stuck  = m_locked && ones;
      e.fail   = m_fail;
      e.cnt16  = cnt16;
      e.cnt2   = cnt2;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit v, input bit b, input bit c);
      bus16.valid_i = v;
      bus16.bit_i   = b;
      bus16.clear_i = c;
      bus2.valid_i  = v;
      bus2.bit_i    = b;
      bus2.clear_i  = c;
   endtask

   task automatic step(input bit v, input bit b, input bit c);
      drive(v, b, c);
      model_edge(v, b, c);
      @(posedge clk);
      #1;
   endtask

   // Sample the generator (optionally corrupted); it advances only on valid.
   task automatic gen_step(input bit v, input bit inv, input bit c);
      bit g;
      bit g_exp;
      int k;
      g = gen_rnd[0];
      if (v) begin
         k     = ghist.size();
         g_exp = (k == 0) ? 1'b0 :
                 ~(gbit(k - 32) ^ gbit(k - 24) ^ gbit(k - 16) ^ gbit(k - 8));
         n_cmp++;
         if (g !== g_exp) begin
            n_err++;
            $display("FAIL gen_bit k=%0d actual=%0b required=%0b", k, g, g_exp);
         end
         ghist.push_back(g);
      end
      gen_en = v;
      step(v, g ^ inv, c);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      #1;
      rst_l  = 1'b0;
      gen_en = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) begin
         model_edge(1'b0, 1'b0, 1'b0);
         @(posedge clk);
         #1;
      end
      rst_l = 1'b1;
   endtask

   // Monitor: every DUT output set is checked against the queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (bus16.locked_o !== mon_e.locked || bus16.err_pulse_o !== mon_e.pulse ||
                bus16.stuck_o !== mon_e.stuck || bus16.fail_o !== mon_e.fail ||
                bus16.err_cnt_o !== 16'(mon_e.cnt16) ||
                bus2.locked_o !== mon_e.locked || bus2.err_pulse_o !== mon_e.pulse ||
                bus2.stuck_o !== mon_e.stuck || bus2.fail_o !== mon_e.fail ||
                bus2.err_cnt_o !== 2'(mon_e.cnt2)) begin
               n_err++;
               $display({"FAIL outputs t=%0t actual lock=%0b/%0b pulse=%0b/%0b stuck=%0b/%0b ",
                         "fail=%0b/%0b cnt=%0d/%0d required lock=%0b pulse=%0b stuck=%0b ",
                         "fail=%0b cnt=%0d/%0d"},
                        $time, bus16.locked_o, bus2.locked_o, bus16.err_pulse_o,
                        bus2.err_pulse_o, bus16.stuck_o, bus2.stuck_o, bus16.fail_o,
                        bus2.fail_o, bus16.err_cnt_o, bus2.err_cnt_o, mon_e.locked,
                        mon_e.pulse, mon_e.stuck, mon_e.fail, mon_e.cnt16, mon_e.cnt2);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      gen_en = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      model_reset();

      // Clean stream from seed 0: lock after 32 samples, then a long error-free run.
      reset_dut();
      repeat (10000) gen_step(1'b1, 1'b0, 1'b0);

      // Single corrupted sample, then let its echoes pass through the taps.
      gen_step(1'b1, 1'b1, 1'b0);
      repeat (60) gen_step(1'b1, 1'b0, 1'b0);

      // Four consecutive corruptions drop lock; re-lock on clean samples; fail is sticky.
      repeat (4) gen_step(1'b1, 1'b1, 1'b0);
      repeat (45) gen_step(1'b1, 1'b0, 1'b0);
      gen_step(1'b1, 1'b0, 1'b1);
      repeat (5) gen_step(1'b1, 1'b0, 1'b0);

      // Isolated corruptions saturate the narrow counter; then clear with a mismatch.
      for (int i = 0; i < 5; i++) begin
         gen_step(1'b1, 1'b1, 1'b0);
         repeat (39) gen_step(1'b1, 1'b0, 1'b0);
      end
      gen_step(1'b1, 1'b1, 1'b1);
      repeat (40) gen_step(1'b1, 1'b0, 1'b0);

      // Generator lock-up pattern: all ones.
      reset_dut();
      repeat (40) step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // Random valid gaps with occasional corruption and clears.
      reset_dut();
      repeat (600) begin
         gen_step(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 31) == 0));
      end

      // Reset in the middle of FILL; fill must restart from zero.
      reset_dut();
      repeat (15) gen_step(1'b1, 1'b0, 1'b0);
      reset_dut();
      repeat (40) gen_step(1'b1, 1'b0, 1'b0);

      gen_en = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
